// File: rtl/insn_encoder_loader.sv
// ---------------------------------------------------------------------------
// insn_encoder_loader
//
// Purpose:
//   Reverse of the processor's instruction decoder. It takes decoded
//   instruction descriptors (a type index plus register, immediate and target
//   fields) on a valid/ready stream. Each descriptor is packed into the
//   32-bit ISA word, and the word is written to consecutive instruction-memory
//   addresses starting at a programmed base. The boot/test loader uses this
//   block to build programs in imem without a pre-assembled image.
//
// Parameters:
//   ADDR_W      imem word-address width
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       pulse while idle: latch start_addr and open a session
//   start_addr  first imem write address of the session
//   in_valid    descriptor valid
//   in_ready    block accepts a descriptor this cycle
//   in_last     descriptor is the final one of the session
//   in_type     instruction type index (0..18 legal)
//   in_rd/in_rs/in_rt/in_shamt  register and shift-amount fields
//   in_imm      I-type immediate
//   in_target   JI-type target
//   imem_we     imem write strobe (one cycle after acceptance)
//   imem_addr   registered write address (holds when idle)
//   imem_data   registered encoded word (holds when idle)
//   busy        high while accepting or draining
//   done        one-cycle pulse at the end of a session
//   err_type    sticky: an illegal type index was consumed
//   err_wrap    sticky: the session reached the top imem address
//   word_count  words written this session
// ---------------------------------------------------------------------------
module insn_encoder_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic              err_type,
  output logic              err_wrap,
  output logic [ADDR_W:0]   word_count
);

  // Type indices as they arrive on in_type.
  localparam logic [4:0] TY_ADD  = 5'd0;
  localparam logic [4:0] TY_ADDI = 5'd1;
  localparam logic [4:0] TY_SUB  = 5'd2;
  localparam logic [4:0] TY_AND  = 5'd3;
  localparam logic [4:0] TY_OR   = 5'd4;
  localparam logic [4:0] TY_SLL  = 5'd5;
  localparam logic [4:0] TY_SRA  = 5'd6;
  localparam logic [4:0] TY_MUL  = 5'd7;
  localparam logic [4:0] TY_DIV  = 5'd8;
  localparam logic [4:0] TY_SW   = 5'd9;
  localparam logic [4:0] TY_LW   = 5'd10;
  localparam logic [4:0] TY_J    = 5'd11;
  localparam logic [4:0] TY_BNE  = 5'd12;
  localparam logic [4:0] TY_JAL  = 5'd13;
  localparam logic [4:0] TY_JR   = 5'd14;
  localparam logic [4:0] TY_BLT  = 5'd15;
  localparam logic [4:0] TY_BEX  = 5'd16;
  localparam logic [4:0] TY_SETX = 5'd17;
  localparam logic [4:0] TY_NOP  = 5'd18;

  // Opcodes placed in bits [31:27] of the ISA word.
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // ALU operation codes placed in bits [6:2] of R-type words.
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4;
  localparam logic [4:0] ALU_SRA = 5'd5;
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  localparam logic [31:0] NOP_WORD = 32'h0000_0020;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } loaderState_e;

  loaderState_e r_state;
  loaderState_e w_nextState;

  logic [ADDR_W-1:0] r_addrCount;
  logic              r_imemWe;
  logic [ADDR_W-1:0] r_imemAddr;
  logic [31:0]       r_imemData;
  logic              r_errType;
  logic              r_errWrap;
  logic [ADDR_W:0]   r_wordCount;

  logic        w_inReady;
  logic        w_accept;
  logic        w_addrTop;
  logic        w_typeValid;
  logic [31:0] w_encoded;

  assign w_accept  = in_valid & w_inReady;
  assign w_addrTop = &r_addrCount;

  // Pack the descriptor into the ISA word. Fields that a format does not use
  // stay zero. Only sll/sra carry the shift amount. A type index above the
  // nop code is flagged illegal, and its word is never written.
  always_comb begin
    w_typeValid = 1'b1;
    w_encoded   = 32'd0;
    case (in_type)
      TY_ADD:  w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, 5'd0, ALU_ADD, 2'b00};
      TY_SUB:  w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, 5'd0, ALU_SUB, 2'b00};
      TY_AND:  w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, 5'd0, ALU_AND, 2'b00};
      TY_OR:   w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, 5'd0, ALU_OR, 2'b00};
      TY_SLL:  w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, in_shamt, ALU_SLL, 2'b00};
      TY_SRA:  w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, in_shamt, ALU_SRA, 2'b00};
      TY_MUL:  w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, 5'd0, ALU_MUL, 2'b00};
      TY_DIV:  w_encoded = {OP_RTYPE, in_rd, in_rs, in_rt, 5'd0, ALU_DIV, 2'b00};
      TY_ADDI: w_encoded = {OP_ADDI, in_rd, in_rs, in_imm};
      TY_SW:   w_encoded = {OP_SW, in_rd, in_rs, in_imm};
      TY_LW:   w_encoded = {OP_LW, in_rd, in_rs, in_imm};
      TY_BNE:  w_encoded = {OP_BNE, in_rd, in_rs, in_imm};
      TY_BLT:  w_encoded = {OP_BLT, in_rd, in_rs, in_imm};
      TY_J:    w_encoded = {OP_J, in_target};
      TY_JAL:  w_encoded = {OP_JAL, in_target};
      TY_BEX:  w_encoded = {OP_BEX, in_target};
      TY_SETX: w_encoded = {OP_SETX, in_target};
      TY_JR:   w_encoded = {OP_JR, in_rd, 22'd0};
      TY_NOP:  w_encoded = NOP_WORD;
      default: w_typeValid = 1'b0;
    endcase
  end

  // Session state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the status outputs that depend only on the state.
  // A session drains after the last descriptor, or after the descriptor
  // taken at the top address, because no further address is available.
  // An illegal descriptor marked last still ends the session, but nothing
  // is written for it.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        w_inReady = 1'b1;
        busy      = 1'b1;
        if (in_valid && (in_last || w_addrTop)) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy        = 1'b1;
        w_nextState = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath. An accepted legal descriptor is registered as a write on the
  // next cycle and advances the address counter. At the top address the
  // counter holds and err_wrap is set instead. Start is seen only in IDLE,
  // so a stray start during a session cannot move the counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addrCount <= '0;
      r_imemWe    <= 1'b0;
      r_imemAddr  <= '0;
      r_imemData  <= '0;
      r_errType   <= 1'b0;
      r_errWrap   <= 1'b0;
      r_wordCount <= '0;
    end else begin
      r_imemWe <= 1'b0;
      if ((r_state == ST_IDLE) && start) begin
        r_addrCount <= start_addr;
        r_wordCount <= '0;
        r_errType   <= 1'b0;
        r_errWrap   <= 1'b0;
      end
      if (w_accept) begin
        if (w_typeValid) begin
          r_imemWe    <= 1'b1;
          r_imemAddr  <= r_addrCount;
          r_imemData  <= w_encoded;
          r_wordCount <= r_wordCount + COUNT_ONE;
          if (w_addrTop) begin
            r_errWrap <= 1'b1;
          end else begin
            r_addrCount <= r_addrCount + ADDR_ONE;
          end
        end else begin
          r_errType <= 1'b1;
        end
      end
    end
  end

  assign in_ready   = w_inReady;
  assign imem_we    = r_imemWe;
  assign imem_addr  = r_imemAddr;
  assign imem_data  = r_imemData;
  assign err_type   = r_errType;
  assign err_wrap   = r_errWrap;
  assign word_count = r_wordCount;

endmodule

// File: tb/tb_insn_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_insn_encoder_loader
//
// Purpose:
//   Testbench for insn_encoder_loader. It applies directed descriptor
//   sessions and compares the imem writes and status outputs with encoded
//   words worked out by hand from the ISA field layout.
// ---------------------------------------------------------------------------
module tb_insn_encoder_loader;

  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [4:0]        in_type;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [16:0]       in_imm;
  logic [26:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              busy;
  logic              done;
  logic              err_type;
  logic              err_wrap;
  logic [ADDR_W:0]   word_count;

  int checkCount = 0;
  int errorCount = 0;

  insn_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_type    (in_type),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .busy       (busy),
    .done       (done),
    .err_type   (err_type),
    .err_wrap   (err_wrap),
    .word_count (word_count)
  );

  // Free-running clock with a 10-unit period.
  always #5 clock = ~clock;

  // Safety net so the run ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge, where inputs are driven and
  // outputs are sampled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one descriptor on the input stream.
  task automatic applyStimulus(input logic valid, input logic last,
                               input logic [4:0] ty, input logic [4:0] rd,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] shamt, input logic [16:0] imm,
                               input logic [26:0] target);
    in_valid  = valid;
    in_last   = last;
    in_type   = ty;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    in_shamt  = shamt;
    in_imm    = imm;
    in_target = target;
  endtask

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one cycle with the given base address.
  task automatic openSession(input logic [ADDR_W-1:0] base);
    start      = 1'b1;
    start_addr = base;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_we", 32'(imem_we), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_data", imem_data, 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_errs", {30'd0, err_type, err_wrap}, 32'd0);
    checkOutput("rst_count", 32'(word_count), 32'd0);
    reset = 1'b0;

    // Session 1: add, addi, sll, then sub (last) back to back.
    openSession(12'h010);
    checkOutput("s1_ready", 32'(in_ready), 32'd1);
    checkOutput("s1_busy", 32'(busy), 32'd1);
    applyStimulus(1, 0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("add_we", 32'(imem_we), 32'd1);
    checkOutput("add_addr", 32'(imem_addr), 32'h010);
    checkOutput("add_data", imem_data, 32'h0044_3000);
    checkOutput("add_count", 32'(word_count), 32'd1);
    applyStimulus(1, 0, 5'd1, 5'd5, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0);
    tick();
    checkOutput("addi_we", 32'(imem_we), 32'd1);
    checkOutput("addi_addr", 32'(imem_addr), 32'h011);
    checkOutput("addi_data", imem_data, 32'h2941_FFFF);
    applyStimulus(1, 0, 5'd5, 5'd4, 5'd4, 5'd0, 5'd3, 17'd0, 27'd0);
    tick();
    checkOutput("sll_addr", 32'(imem_addr), 32'h012);
    checkOutput("sll_data", imem_data, 32'h0108_0190);
    applyStimulus(1, 1, 5'd2, 5'd1, 5'd2, 5'd3, 5'd7, 17'd0, 27'd0);
    tick();
    checkOutput("sub_addr", 32'(imem_addr), 32'h013);
    checkOutput("sub_data", imem_data, 32'h0044_3004);
    checkOutput("sub_ready", 32'(in_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("s1_done", 32'(done), 32'd1);
    checkOutput("s1_done_we", 32'(imem_we), 32'd0);
    checkOutput("s1_done_busy", 32'(busy), 32'd0);
    checkOutput("s1_count", 32'(word_count), 32'd4);
    tick();
    checkOutput("s1_done_pulse", 32'(done), 32'd0);

    // Session 2: jal, then nop (last) with garbage fields; start mid-session.
    openSession(12'h100);
    start      = 1'b1;
    start_addr = 12'h555;
    applyStimulus(1, 0, 5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h100);
    tick();
    start = 1'b0;
    checkOutput("jal_addr", 32'(imem_addr), 32'h100);
    checkOutput("jal_data", imem_data, 32'h1800_0100);
    applyStimulus(1, 1, 5'd18, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FFFFFF);
    tick();
    checkOutput("nop_addr", 32'(imem_addr), 32'h101);
    checkOutput("nop_data", imem_data, 32'h0000_0020);
    checkOutput("nop_ready", 32'(in_ready), 32'd0);
    checkOutput("nop_busy", 32'(busy), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("s2_done", 32'(done), 32'd1);
    checkOutput("s2_count", 32'(word_count), 32'd2);
    checkOutput("s2_hold_data", imem_data, 32'h0000_0020);
    tick();

    // Session 3: add, illegal type 25, add (last).
    openSession(12'h200);
    applyStimulus(1, 0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("s3_add1_addr", 32'(imem_addr), 32'h200);
    checkOutput("s3_add1_data", imem_data, 32'h0042_1000);
    applyStimulus(1, 0, 5'd25, 5'd9, 5'd9, 5'd9, 5'd9, 17'h1234, 27'h1234);
    tick();
    checkOutput("bad_we", 32'(imem_we), 32'd0);
    checkOutput("bad_err", 32'(err_type), 32'd1);
    checkOutput("bad_count", 32'(word_count), 32'd1);
    applyStimulus(1, 1, 5'd0, 5'd2, 5'd2, 5'd2, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("s3_add2_addr", 32'(imem_addr), 32'h201);
    checkOutput("s3_add2_data", imem_data, 32'h0084_2000);
    checkOutput("s3_count", 32'(word_count), 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("s3_done", 32'(done), 32'd1);
    tick();

    // Session 4: setx, then illegal type 30 marked last.
    openSession(12'h300);
    checkOutput("s4_err_clear", 32'(err_type), 32'd0);
    applyStimulus(1, 0, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h1234567);
    tick();
    checkOutput("setx_data", imem_data, 32'hA923_4567);
    applyStimulus(1, 1, 5'd30, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1);
    tick();
    checkOutput("badlast_we", 32'(imem_we), 32'd0);
    checkOutput("badlast_ready", 32'(in_ready), 32'd0);
    checkOutput("badlast_err", 32'(err_type), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("s4_done", 32'(done), 32'd1);
    checkOutput("s4_done_we", 32'(imem_we), 32'd0);
    checkOutput("s4_count", 32'(word_count), 32'd1);
    tick();

    // Session 5: start near the top address and offer three words.
    openSession(12'hFFE);
    applyStimulus(1, 0, 5'd9, 5'd1, 5'd2, 5'd0, 5'd0, 17'h10, 27'd0);
    tick();
    checkOutput("sw_addr", 32'(imem_addr), 32'hFFE);
    checkOutput("sw_data", imem_data, 32'h3844_0010);
    checkOutput("sw_wrap", 32'(err_wrap), 32'd0);
    applyStimulus(1, 0, 5'd10, 5'd3, 5'd4, 5'd0, 5'd0, 17'h5, 27'd0);
    tick();
    checkOutput("lw_addr", 32'(imem_addr), 32'hFFF);
    checkOutput("lw_data", imem_data, 32'h40C8_0005);
    checkOutput("lw_wrap", 32'(err_wrap), 32'd1);
    checkOutput("lw_ready", 32'(in_ready), 32'd0);
    applyStimulus(1, 0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd1);
    tick();
    checkOutput("wrap_third_we", 32'(imem_we), 32'd0);
    checkOutput("wrap_done", 32'(done), 32'd1);
    checkOutput("wrap_count", 32'(word_count), 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Session 6: reset in the middle of a stream, then restart at 0.
    openSession(12'h040);
    applyStimulus(1, 0, 5'd4, 5'd3, 5'd4, 5'd5, 5'd0, 17'd0, 27'd0);
    tick();
    checkOutput("or_addr", 32'(imem_addr), 32'h040);
    checkOutput("or_data", imem_data, 32'h00C8_500C);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_we", 32'(imem_we), 32'd0);
    checkOutput("mid_rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("mid_rst_data", imem_data, 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_count", 32'(word_count), 32'd0);
    tick();
    checkOutput("mid_rst_hold_we", 32'(imem_we), 32'd0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("post_rst_we", 32'(imem_we), 32'd0);
    openSession(12'h000);
    applyStimulus(1, 1, 5'd14, 5'd7, 5'd3, 5'd3, 5'd3, 17'h3, 27'h3);
    tick();
    checkOutput("jr_we", 32'(imem_we), 32'd1);
    checkOutput("jr_addr", 32'(imem_addr), 32'h000);
    checkOutput("jr_data", imem_data, 32'h21C0_0000);
    checkOutput("jr_count", 32'(word_count), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("s6_done", 32'(done), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/insn_encoder_loader.md
Name: insn_encoder_loader

Overview:
- Inverse of the processor's instruction decoder.
- Accepts decoded instruction descriptors (type index plus register/immediate/target fields) over a valid/ready stream.
- Encodes each descriptor into the 32-bit ISA word and writes it sequentially into instruction memory from a programmed base address.
- Used by the boot/test loader to build programs in imem without a pre-assembled image.

Parameters:
- ADDR_W, 12, imem word-address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse in IDLE: latch start_addr, begin session.
- start_addr  in  ADDR_W  first imem write address.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  block accepts a descriptor this cycle.
- in_last  in  1  descriptor is the final one of the session.
- in_type  in  5  type index: 0 add, 1 addi, 2 sub, 3 and, 4 or, 5 sll, 6 sra, 7 mul, 8 div, 9 sw, 10 lw, 11 j, 12 bne, 13 jal, 14 jr, 15 blt, 16 bex, 17 setx, 18 nop.
- in_rd, in_rs, in_rt, in_shamt  in  5 each  register and shift fields.
- in_imm  in  17  I-type immediate.
- in_target  in  27  JI-type target.
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_data  out  32  encoded word.
- busy  out  1  high in ACTIVE and DRAIN.
- done  out  1  one-cycle pulse at session end.
- err_type  out  1  sticky: in_type > 18 was seen; cleared by start.
- err_wrap  out  1  sticky: session hit the top imem address; cleared by start.
- word_count  out  ADDR_W+1  words written this session; cleared by start.

Behaviour:
- Reset (asynchronous): every output is 0, state IDLE.
- States and transitions:
  - IDLE: in_ready=0. start latches the address counter and clears word_count, err_type and err_wrap, then goes to ACTIVE.
  - ACTIVE: in_ready=1. A handshake completes when in_valid and in_ready are both high. If the accepted descriptor has in_last, or its address is all-ones, go to DRAIN.
  - DRAIN: in_ready=0; wait one cycle for the final write, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start outside IDLE is ignored.
- Latency: descriptor accepted at cycle N gives imem_we=1 at cycle N+1, with imem_addr/imem_data registered. A word can be accepted every cycle, so throughput is 1 word/clock.
- Address counter: increments after each valid encoded write.
  - A valid descriptor accepted at address all-ones is written, sets err_wrap and is treated as last; the address never wraps to 0.
  - word_count increments with each imem_we.
- Encoding, with bit fields opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2]. Unused bits are 0.
  - R-type (0, 2–8): opcode 00000; rd, rs, rt; aluop = add 0, sub 1, and 2, or 3, sll 4, sra 5, mul 6, div 7. Shamt is carried only for sll/sra, else 0.
  - I-type: imm in [16:0] with rd, rs.
    - addi 00101, sw 00111, lw 01000, bne 00010, blt 00110.
  - JI-type: target in [26:0].
    - j 00001, jal 00011, bex 10110, setx 10101.
  - jr: opcode 00100, rd only.
  - nop: 32'h00000020 (aluop 01000), all inputs ignored.
- Invalid type (19–31):
  - descriptor is consumed (handshake completes);
  - err_type set; no write; address and count unchanged;
  - in_last is still honoured, and done follows 2 cycles later with no final write.
- imem_we is deasserted in every cycle without a pending encoded word. imem_addr/imem_data hold their last value.

Test Plan:
- Reset, start with start_addr=0x010, push add (rd1 rs2 rt3) -> next cycle imem_we=1, imem_addr=0x010, imem_data=0x00443000.
- Back-to-back addi (rd5, rs0, imm 0x1FFFF) then sll (rd4 rs4 shamt3); in_valid held 2 cycles.
  - 0x2941FFFF at 0x011 and 0x01080190 at 0x012 on consecutive cycles.
  - Second case: sub with shamt 7 -> shamt bits 0.
- jal target 0x100, then nop with in_last.
  - Writes 0x18000100, then 0x00000020.
  - done pulses the cycle after the nop write; word_count=2; in_ready low from the cycle after nop accept.
- add, type 25, add.
  - err_type=1; the two adds land at consecutive addresses; word_count=2.
- ADDR_W=4, start_addr=0xE, offer 3 words.
  - Writes at 0xE and 0xF; err_wrap=1; third word not accepted; done pulses.
- Assert reset mid-stream with in_valid high.
  - All outputs 0 immediately; no further imem_we.
  - A subsequent start at 0x000 writes the next word at 0x000 with word_count restarted.
